// File: rtl/register_ce_pkg.sv
// Shared constants for the clock-enabled holding register.
package register_ce_pkg;

    // Default data width used when an instance does not override NBITS.
    localparam int REGISTER_CE_DEFAULT_NBITS = 16;

endpackage : register_ce_pkg

// File: rtl/register_ce.sv
// Parameterised data register with clock enable, synchronous active-low
// reset and a one-cycle "updated" strobe following every load.
module register_ce
    import register_ce_pkg::*;
#(
    parameter int                NBITS       = REGISTER_CE_DEFAULT_NBITS,
    parameter logic [NBITS-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ce,
    input  logic [NBITS-1:0] din,
    output logic [NBITS-1:0] dout,
    output logic             updated
);

    logic [NBITS-1:0] dout_reg;
    logic             updated_reg;

    // Data register and load strobe: reset wins, otherwise capture on ce and
    // leave the data flop untouched (not rewritten) while ce is low.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dout_reg    <= RESET_VALUE;
            updated_reg <= 1'b0;
        end else begin
            updated_reg <= ce;
            if (ce) begin
                dout_reg <= din;
            end
        end
    end

    assign dout    = dout_reg;
    assign updated = updated_reg;

endmodule : register_ce

// File: tb/tb_register_ce.sv
// Directed self-checking bench for register_ce: two instances share all
// inputs, one with the default reset value and one with 0x00A5.
`timescale 1ns/1ps
module tb_register_ce;

    localparam int NB = 16;

    logic          clk;
    logic          resetn;
    logic          ce;
    logic [NB-1:0] din;
    logic [NB-1:0] dout0;
    logic          upd0;
    logic [NB-1:0] dout5;
    logic          upd5;

    int checks = 0;
    int errors = 0;

    register_ce #(.NBITS(NB)) dut0 (
        .clk     (clk),
        .resetn  (resetn),
        .ce      (ce),
        .din     (din),
        .dout    (dout0),
        .updated (upd0)
    );

    register_ce #(.NBITS(NB), .RESET_VALUE(16'h00A5)) dut5 (
        .clk     (clk),
        .resetn  (resetn),
        .ce      (ce),
        .din     (din),
        .dout    (dout5),
        .updated (upd5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; ce = 1'b0; din = '0;
        repeat (5) tick();
        checks++;
        if (dout0 !== 16'h0000 || upd0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut0: dout=%h updated=%b expected dout=0000 updated=0", dout0, upd0);
        end
        checks++;
        if (dout5 !== 16'h00A5 || upd5 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut5: dout=%h updated=%b expected dout=00a5 updated=0", dout5, upd5);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (dout0 !== 16'h0000 || upd0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: dout=%h updated=%b expected dout=0000 updated=0", dout0, upd0);
        end
        $display("reset: dout0=%h dout5=%h updated=%b", dout0, dout5, upd0);
    endtask

    task automatic test_hold_ce_low();
        int bad = 0;
        din = 16'h0001; ce = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (dout0 !== 16'h0000 || upd0 !== 1'b0) begin
                errors++;
                bad++;
                if (bad <= 3)
                    $display("FAIL hold_ce_low cycle %0d: dout=%h updated=%b expected dout=0000 updated=0", i, dout0, upd0);
            end
        end
        $display("hold_ce_low: 100 cycles din=0001 ce=0 dout=%h", dout0);
    endtask

    task automatic test_single_pulse();
        din = 16'h0001; ce = 1'b1;
        tick();
        ce = 1'b0;
        checks++;
        if (dout0 !== 16'h0001 || upd0 !== 1'b1) begin
            errors++;
            $display("FAIL pulse_load: dout=%h updated=%b expected dout=0001 updated=1", dout0, upd0);
        end
        tick();
        checks++;
        if (dout0 !== 16'h0001 || upd0 !== 1'b0) begin
            errors++;
            $display("FAIL pulse_after: dout=%h updated=%b expected dout=0001 updated=0", dout0, upd0);
        end
        $display("single_pulse: din=0001 dout=%h updated=%b", dout0, upd0);
    endtask

    task automatic test_long_hold();
        int bad = 0;
        din = 16'h0002; ce = 1'b0;
        repeat (100) tick();
        checks++;
        if (dout0 !== 16'h0001 || upd0 !== 1'b0) begin
            errors++;
            $display("FAIL long_hold_pre: dout=%h updated=%b expected dout=0001 updated=0", dout0, upd0);
        end
        ce = 1'b1;
        tick();
        ce = 1'b0;
        checks++;
        if (dout0 !== 16'h0002 || upd0 !== 1'b1) begin
            errors++;
            $display("FAIL long_hold_load: dout=%h updated=%b expected dout=0002 updated=1", dout0, upd0);
        end
        din = 16'h7777;
        for (int i = 0; i < 1000; i++) begin
            tick();
            checks++;
            if (dout0 !== 16'h0002 || upd0 !== 1'b0) begin
                errors++;
                bad++;
                if (bad <= 3)
                    $display("FAIL long_hold cycle %0d: dout=%h updated=%b expected dout=0002 updated=0", i, dout0, upd0);
            end
        end
        $display("long_hold: loaded 0002, held 1000 cycles dout=%h", dout0);
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] seq [4];
        seq[0] = 16'h0003; seq[1] = 16'h0004; seq[2] = 16'hFFFF; seq[3] = 16'h8000;
        ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = seq[i];
            tick();
            checks++;
            if (dout0 !== seq[i] || upd0 !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d]: dout=%h updated=%b expected dout=%h updated=1", i, dout0, upd0, seq[i]);
            end
            $display("back_to_back[%0d]: din=%h dout=%h updated=%b", i, seq[i], dout0, upd0);
        end
        ce = 1'b0;
        tick();
        checks++;
        if (dout0 !== 16'h8000 || upd0 !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_end: dout=%h updated=%b expected dout=8000 updated=0", dout0, upd0);
        end
    endtask

    task automatic test_same_value();
        din = 16'h8000; ce = 1'b1;
        tick();
        ce = 1'b0;
        checks++;
        if (dout0 !== 16'h8000 || upd0 !== 1'b1) begin
            errors++;
            $display("FAIL same_value: dout=%h updated=%b expected dout=8000 updated=1", dout0, upd0);
        end
        $display("same_value: reload 8000 updated=%b", upd0);
        tick();
    endtask

    task automatic test_reset_override();
        din = 16'h1234; ce = 1'b1; resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++;
        if (dout5 !== 16'h00A5 || upd5 !== 1'b0) begin
            errors++;
            $display("FAIL reset_override_dut5: dout=%h updated=%b expected dout=00a5 updated=0", dout5, upd5);
        end
        checks++;
        if (dout0 !== 16'h0000 || upd0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_override_dut0: dout=%h updated=%b expected dout=0000 updated=0", dout0, upd0);
        end
        $display("reset_override: ce=1 din=1234 resetn=0 dout5=%h updated=%b", dout5, upd5);
        tick();
        ce = 1'b0;
        checks++;
        if (dout5 !== 16'h1234 || upd5 !== 1'b1) begin
            errors++;
            $display("FAIL reload_after_reset: dout=%h updated=%b expected dout=1234 updated=1", dout5, upd5);
        end
        checks++;
        if (dout0 !== 16'h1234) begin
            errors++;
            $display("FAIL reload_after_reset_dut0: dout=%h expected 1234", dout0);
        end
        $display("reload_after_reset: dout5=%h updated=%b", dout5, upd5);
        tick();
        checks++;
        if (dout5 !== 16'h1234 || upd5 !== 1'b0) begin
            errors++;
            $display("FAIL post_reload_hold: dout=%h updated=%b expected dout=1234 updated=0", dout5, upd5);
        end
    endtask

    initial begin
        resetn = 1'b0; ce = 1'b0; din = '0;
        test_reset();
        test_hold_ce_low();
        test_single_pulse();
        test_long_hold();
        test_back_to_back();
        test_same_value();
        test_reset_override();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_register_ce
